coin_front_end: RTL

- Upstream stage of the vending controller. Converts two raw, bouncy coin-sensor lines (5-unit and 10-unit) into clean one-cycle coin codes on x[1:0].
- x connects directly to the vending FSM's x input, using the same encoding: 00 = no coin, 01 = 5, 10 = 10. Code 11 is never driven.
- Synchronises and debounces each line, and queues coins in a small FIFO so bursts are not lost.
- Spaces emitted codes so the FSM sees each coin in exactly one clock.
- Rejects coins when disabled or full, and signals the coin-return mechanism.

---
 rtl/coin_front_end.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/coin_front_end.sv
// Coin front end: sync + debounce two coin sensors, queue coins, emit one-cycle codes on x.
// Latency: raw first sampled at edge k -> enqueue at k+2+D -> x valid after edge k+3+D (empty queue).
// Backpressure: none upstream; coins arriving when disabled or full are returned via coin_return.
module coin_front_end #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          accept_en,
  output logic [1:0]                    x,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          coin_return,
  output logic [1:0]                    return_code
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_5    = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} emit_st_e;

  // Bit 0 tracks the 5-unit line, bit 1 the 10-unit line.
  logic [1:0]     meta_q, sync_q;
  logic [1:0]     stable_q, stable_d, stable_dly_q;
  logic [DCW-1:0] cnt_q [2];
  logic [DCW-1:0] cnt_d [2];
  logic [1:0]     coin_ev;

  logic           pend10_q, pend10_d;
  logic           coin_vld;
  logic [1:0]     coin_code;
  logic           push, reject, pop;

  logic [1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  logic           ret_q;
  logic [1:0]     ret_code_q;

  emit_st_e       state_q;
  logic [GW-1:0]  gap_cnt_q;
  logic [1:0]     x_q;
  logic           emit_ready;

  // Debounce: a line's stable level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  assign coin_ev = stable_q & ~stable_dly_q;

  // Synchroniser, debounce state and rising-edge history for both lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= '0;
      sync_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '{default: '0};
    end else begin
      meta_q       <= {coin10_raw, coin5_raw};
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Arbitrate one coin per cycle: 5 wins a tie, the 10 waits one cycle in pend10.
  always_comb begin
    coin_vld  = 1'b0;
    coin_code = CODE_NONE;
    pend10_d  = pend10_q;
    if (coin_ev[0]) begin
      coin_vld  = 1'b1;
      coin_code = CODE_5;
      pend10_d  = pend10_q | coin_ev[1];
    end else if (pend10_q || coin_ev[1]) begin
      coin_vld  = 1'b1;
      coin_code = CODE_10;
      pend10_d  = 1'b0;
    end
  end

  // Room is judged on the count at the start of the cycle, so a same-cycle pop never frees a slot.
  assign push   = coin_vld && accept_en && (count_q < CW'(FIFO_DEPTH));
  assign reject = coin_vld && !push;

  // The emitter may load a new code when idle, straight after a code if there is no gap,
  // or on the last gap cycle, so x shows exactly GAP_CYCLES zero cycles between codes.
  assign emit_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_EMIT) && (GAP_CYCLES == 0)) ||
                      ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST));
  assign pop        = emit_ready && (count_q != '0);

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= coin_code;
    end
  end

  // Queue control, pending-10 flag and the registered coin-return pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend10_q   <= 1'b0;
      ret_q      <= 1'b0;
      ret_code_q <= CODE_NONE;
    end else begin
      pend10_q   <= pend10_d;
      count_q    <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      ret_q      <= reject;
      ret_code_q <= reject ? coin_code : CODE_NONE;
    end
  end

  // Emitter FSM: one cycle of code on x per popped coin, followed by the enforced gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      x_q       <= CODE_NONE;
    end else if (pop) begin
      x_q     <= mem_q[rd_ptr_q];
      state_q <= ST_EMIT;
    end else begin
      x_q <= CODE_NONE;
      case (state_q)
        ST_EMIT: begin
          gap_cnt_q <= '0;
          state_q   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign fifo_count  = count_q;
  assign coin_return = ret_q;
  assign return_code = ret_code_q;

endmodule
